// File: rtl/axis_output_framer.sv
// AXI4-Stream output framer: FWFT pixel FIFO, frame counter with TLAST, overflow flag.
// Define AXIS_OUTPUT_FRAMER_INTR_EN to drive o_intr during the end-of-frame cycle.
module axis_output_framer #(
  parameter int FRAME_PIXELS = 262144,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        enable,
  input  logic [23:0] i_pixel,
  input  logic        i_valid,
  output logic        o_afull,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        o_overflow,
  output logic        o_intr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [PW-1:0] LAST_C  = PW'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_EOF
  } state_t;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] count, count_n;
  logic [23:0]   head_q, head_n;
  logic [1:0]    sync_q;
  logic [PW-1:0] pcnt;
  state_t        state;
  logic          full, rd, wr, drop, push;
  logic          afull_q, ovf_q;

  assign full  = (count == DEPTH_C);
  assign rd    = M_AXIS_TVALID && M_AXIS_TREADY;
  assign push  = i_valid && enable && sync_q[1];
  assign wr    = push && (!full || rd);
  assign drop  = push && full && !rd;

  assign rptr_n  = rd ? rptr + AW'(1) : rptr;
  assign count_n = count + CW'(wr) - CW'(rd);

  // Next head: bypass when the incoming pixel becomes the only entry.
  always_comb begin
    head_n = '0;
    if (count_n != '0) begin
      if (wr && (wptr == rptr_n)) head_n = i_pixel;
      else                        head_n = mem[rptr_n];
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr) mem[wptr] <= i_pixel;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sync_q  <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      head_q  <= '0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], 1'b1};
      rptr    <= rptr_n;
      count   <= count_n;
      head_q  <= head_n;
      afull_q <= (count_n >= AFULL_C);
      if (wr)   wptr  <= wptr + AW'(1);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign M_AXIS_TVALID = (count != '0);
  assign M_AXIS_TDATA  = {8'h00, head_q};
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (pcnt == LAST_C);
  assign o_afull       = afull_q;
  assign o_overflow    = ovf_q;

`ifdef AXIS_OUTPUT_FRAMER_INTR_EN
  logic intr_q;
  assign o_intr = intr_q;
`else
  assign o_intr = 1'b0;
`endif

  // Every TLAST handshake lands in S_EOF, so intr mirrors that entry.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= S_IDLE;
      pcnt  <= '0;
`ifdef AXIS_OUTPUT_FRAMER_INTR_EN
      intr_q <= 1'b0;
`endif
    end else begin
`ifdef AXIS_OUTPUT_FRAMER_INTR_EN
      intr_q <= rd && M_AXIS_TLAST;
`endif
      if (rd) pcnt <= M_AXIS_TLAST ? '0 : pcnt + PW'(1);
      unique case (state)
        S_IDLE:
          if (rd) state <= M_AXIS_TLAST ? S_EOF : S_STREAM;
        S_STREAM:
          if (rd && M_AXIS_TLAST) state <= S_EOF;
        S_EOF:
          if (rd) state <= M_AXIS_TLAST ? S_EOF : S_STREAM;
          else    state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_output_framer.sv
// Scoreboard bench for axis_output_framer with a queue-level reference model.
// Directed frame, fill/overflow, stall, reset and gating cases plus random traffic.
module tb_axis_output_framer;

  localparam int FP    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] i_pixel = '0;
  logic        i_valid = 1'b0;
  logic        M_AXIS_TREADY = 1'b0;
  logic        o_afull, M_AXIS_TVALID, M_AXIS_TLAST;
  logic        o_overflow, o_intr;
  logic [31:0] M_AXIS_TDATA;

  axis_output_framer #(
    .FRAME_PIXELS(FP),
    .FIFO_DEPTH(DEPTH),
    .AFULL_MARGIN(4)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .enable(enable),
    .i_pixel(i_pixel),
    .i_valid(i_valid),
    .o_afull(o_afull),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .o_overflow(o_overflow),
    .o_intr(o_intr)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [23:0] pix;
    bit          last;
  } beat_t;

  beat_t sb[$];
  int errors = 0;
  int checks = 0;
  int occ = 0, acc_n = 0, rd_n = 0, rel = 0;
  bit ovf_e = 0, intr_e = 0, afull_e = 0;
  int hs_cnt = 0, intr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, frame position and flags from the rules.
  always @(posedge ACLK or negedge ARESETn) begin
    bit rd, wr, pushv;
    if (!ARESETn) begin
      occ = 0; acc_n = 0; rd_n = 0; rel = 0;
      ovf_e = 0; intr_e = 0; afull_e = 0;
      sb.delete();
    end else begin
      rd = (occ > 0) && M_AXIS_TREADY;
      pushv = i_valid && enable && (rel >= 2);
      wr = pushv && ((occ < DEPTH) || rd);
      if (pushv && occ == DEPTH && !rd) ovf_e = 1;
`ifdef AXIS_OUTPUT_FRAMER_INTR_EN
      intr_e = rd && ((rd_n % FP) == FP - 1);
`else
      intr_e = 0;
`endif
      if (rd) begin occ--; rd_n++; end
      if (wr) begin
        sb.push_back('{pix: i_pixel, last: ((acc_n % FP) == FP - 1)});
        occ++; acc_n++;
      end
      afull_e = (occ >= AFULL);
      if (rel < 4) rel++;
    end
  end

  // Monitor: handshake happens at the next rising edge with these values.
  always @(negedge ACLK) begin
    beat_t b;
    if (!ARESETn) begin
      chk("rst_outputs",
          {M_AXIS_TVALID, M_AXIS_TLAST, o_afull, o_intr, o_overflow},
          5'b0);
      chk("rst_tdata", M_AXIS_TDATA, 32'h0);
    end else begin
      chk("tvalid", {31'b0, M_AXIS_TVALID}, {31'b0, occ > 0});
      if (M_AXIS_TVALID) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          b = sb[0];
          chk("tdata", M_AXIS_TDATA, {8'h00, b.pix});
          chk("tlast", {31'b0, M_AXIS_TLAST}, {31'b0, b.last});
          if (M_AXIS_TREADY) begin
            void'(sb.pop_front());
            hs_cnt++;
          end
        end
      end
      chk("afull", {31'b0, o_afull}, {31'b0, afull_e});
      chk("overflow", {31'b0, o_overflow}, {31'b0, ovf_e});
      chk("intr", {31'b0, o_intr}, {31'b0, intr_e});
      if (o_intr) intr_cnt++;
    end
  end

  task automatic step(input bit v, input bit en, input logic [23:0] p,
                      input bit rdy);
    i_valid = v;
    enable = en;
    i_pixel = p;
    M_AXIS_TREADY = rdy;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 1, 24'h0, rdy);
  endtask

  task automatic do_reset();
    ARESETn = 0;
    idle(2, 0);
    ARESETn = 1;
    idle(3, 0);
  endtask

  int h0, i0;
  logic [23:0] frame4 [4];

  initial begin
    frame4[0] = 24'h112233; frame4[1] = 24'h223344;
    frame4[2] = 24'h334455; frame4[3] = 24'h445566;
    @(posedge ACLK); #1;
    do_reset();

    // One frame at full rate.
    for (int i = 0; i < 4; i++) step(1, 1, frame4[i], 1);
    idle(6, 1);

    // Fill with no readers, overflow, then drain.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 1, 24'h100 + 24'(i), 0);
    chk("fill_afull", {31'b0, o_afull}, 32'd1);
    chk("fill_ovf0", {31'b0, o_overflow}, 32'd0);
    step(1, 1, 24'hDEAD01, 0);
    chk("ovf_set", {31'b0, o_overflow}, 32'd1);
    h0 = hs_cnt;
    idle(24, 1);
    chk("drain16", hs_cnt - h0, 32'd16);

    // Full FIFO with concurrent read and write.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 1, 24'h200 + 24'(i), 0);
    for (int i = 0; i < 10; i++) step(1, 1, 24'h300 + 24'(i), 1);
    step(0, 1, 24'h0, 0);
    chk("rw_full_ovf", {31'b0, o_overflow}, 32'd0);
    chk("rw_full_afull", {31'b0, o_afull}, 32'd1);
    idle(24, 1);

    // Alternating ready over two frames.
    do_reset();
    i0 = intr_cnt;
    for (int i = 0; i < 28; i++)
      step(i < 8, 1, 24'($urandom), (i % 2) == 0);
`ifdef AXIS_OUTPUT_FRAMER_INTR_EN
    chk("intr_pulses", intr_cnt - i0, 32'd2);
`else
    chk("intr_pulses", intr_cnt - i0, 32'd0);
`endif

    // Reset mid-frame after two beats.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, frame4[i], 0);
    idle(2, 1);
    M_AXIS_TREADY = 0;
    ARESETn = 0;
    #1;
    chk("mid_rst_tvalid", {31'b0, M_AXIS_TVALID}, 32'd0);
    chk("mid_rst_tdata", M_AXIS_TDATA, 32'h0);
    chk("mid_rst_afull", {31'b0, o_afull}, 32'd0);
    @(posedge ACLK); #1;
    ARESETn = 1;
    idle(3, 0);
    for (int i = 0; i < 4; i++) step(1, 1, frame4[i] ^ 24'h0F0F0F, 1);
    idle(6, 1);

    // Gated writes.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 24'($urandom), 1);
    chk("gate_tvalid", {31'b0, M_AXIS_TVALID}, 32'd0);
    chk("gate_ovf", {31'b0, o_overflow}, 32'd0);

    // Writes offered right at reset release are held off by the synchronizer.
    ARESETn = 0;
    idle(2, 0);
    ARESETn = 1;
    for (int i = 0; i < 4; i++) step(1, 1, 24'h500 + 24'(i), 0);
    idle(8, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
           24'($urandom), $urandom_range(0, 1) == 1);
    idle(40, 1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
